vec_pipe_chain: RTL and testbench
=================================

VEC_PIPE_CHAIN -- requirements
Module: vec_pipe_chain

Interface
REQ-001 SHALL have parameter REGISTER_SIZE, default 8, the element width in bits.
REQ-002 SHALL have parameter VECTOR_SIZE, default 4, the number of elements per vector.
REQ-003 SHALL have parameter SEL_BITS, default 4, the register-select width.
REQ-004 SHALL have parameter CTRL_W, default 25, the condensed control-word width.
REQ-005 SHALL have parameter STAGES, default 3 (legal range 1..8), the pipeline depth.
REQ-006 SHALL have one clock and an asynchronous active-low reset: clk input 1 rising-edge clock; rst input 1 asynchronous active-low reset.
REQ-007 in_valid input 1: an instruction is presented.
REQ-008 in_ctrl input CTRL_W: the control word.
REQ-009 in_vec1, in_vec2 input VECTOR_SIZE x REGISTER_SIZE: the operand vectors.
REQ-010 in_rsel1, in_rsel2 input SEL_BITS: the source registers read by the instruction.
REQ-011 in_rdst input SEL_BITS and in_wr_en input 1: the destination register and write intent.
REQ-012 stall input 1 (freeze the whole chain) and flush input 1 (kill all in-flight entries).
REQ-013 in_ready output 1: the instruction is accepted this cycle.
REQ-014 hazard output 1: a read-after-write conflict is detected.
REQ-015 out_valid output 1; out_ctrl, out_vec1, out_vec2, out_rdst, out_wr_en outputs: the last-stage contents.
REQ-016 occupancy output $clog2(STAGES+1): the count of valid stages.

Function
REQ-017 The chain SHALL be STAGES registered slots, each holding valid, ctrl, vec1, vec2, rdst and wr_en.
REQ-018 Outputs SHALL be driven directly from slot STAGES-1, giving a latency of exactly STAGES cycles with no stalls.
REQ-019 hazard SHALL be 1 when in_valid=1 and any valid slot has wr_en=1 and rdst equal to in_rsel1 or in_rsel2.
REQ-020 in_ready SHALL equal !stall && !hazard && !flush; this is purely combinational.
REQ-021 On an edge with stall=0 and flush=0, every slot SHALL shift by one, and slot 0 SHALL load the input with valid=in_valid&&in_ready.
REQ-022 A bubble (valid=0, payload unchanged-don't-care) SHALL enter slot 0 when an instruction is not accepted.
REQ-023 On an edge with stall=1 and flush=0, all slots SHALL hold their contents, and outputs SHALL be stable.
REQ-024 On an edge with flush=1, every slot valid SHALL clear regardless of stall, and the input SHALL be dropped; flush has priority over stall.
REQ-025 occupancy SHALL equal the number of slots with valid=1 after each edge; it is 0 when empty and STAGES when full.
REQ-026 A slot leaving the chain SHALL NOT be compared for hazard on the cycle after it exits (no wrap-around).

Reset
REQ-027 While rst=0, all valid bits, payloads, occupancy and statistics counters SHALL be 0, so out_valid=0 and outputs are 0.
REQ-028 Reset asserted mid-operation SHALL discard in-flight entries immediately, with no partial shift.

Configuration
REQ-029 With macro VEC_PIPE_STATS_EN defined, the block SHALL add outputs stall_cnt, bubble_cnt and flush_cnt, each 16 bits and saturating at 16'hFFFF.
REQ-030 stall_cnt SHALL increment on cycles where stall=1.
REQ-031 bubble_cnt SHALL increment when a bubble enters with stall=0 and flush=0.
REQ-032 flush_cnt SHALL increment on cycles where flush=1.
REQ-033 Without VEC_PIPE_STATS_EN, these ports and counters SHALL be absent and the block's behaviour is otherwise identical.

Structure
REQ-034 Package vec_pipe_pkg SHALL hold the vec_t packed-array typedef (VECTOR_SIZE x REGISTER_SIZE), the slot struct typedef and the default parameter constants.
REQ-035 One sub-module, vec_pipe_slot, SHALL implement a single slot register with load, hold and kill controls; it is instantiated STAGES times via generate.

Verification
REQ-036 Reset then drive in_valid=1 with in_ctrl=25'h0000A5 for one cycle, STAGES=3 -> out_valid=1 with out_ctrl=25'h0000A5 exactly 3 cycles later, and occupancy sequence 1,1,1,0.
REQ-037 Issue rdst=4, wr_en=1, then next cycle in_rsel1=4 -> hazard=1 and in_ready=0 for 3 cycles, then the instruction is accepted; bubble_cnt=3 when STATS_EN is defined.
REQ-038 Fill 3 entries then hold stall=1 for 5 cycles -> outputs frozen, occupancy=3, stall_cnt=5.
REQ-039 Assert stall=1 and flush=1 together with 3 valid slots -> next cycle occupancy=0 and out_valid=0; flush_cnt=1.
REQ-040 Pull rst low mid-stream with 2 valid slots -> out_valid=0 immediately, before the next clock edge.
REQ-041 Hold stall=1 for 70000 cycles with STATS_EN defined -> stall_cnt=16'hFFFF with no wrap.

Source files
------------

// File: rtl/vec_pipe_pkg.sv
// Shared types and default constants for the vector pipeline chain.
// The optional statistics counters (VEC_PIPE_STATS_EN) use sat_inc16.
package vec_pipe_pkg;

  localparam int unsigned DEF_REGISTER_SIZE = 8;
  localparam int unsigned DEF_VECTOR_SIZE   = 4;
  localparam int unsigned DEF_SEL_BITS      = 4;
  localparam int unsigned DEF_CTRL_W        = 25;
  localparam int unsigned DEF_STAGES        = 3;

  typedef logic [DEF_VECTOR_SIZE-1:0][DEF_REGISTER_SIZE-1:0] vec_t;

  typedef struct packed {
    logic                    valid;
    logic [DEF_CTRL_W-1:0]   ctrl;
    vec_t                    vec1;
    vec_t                    vec2;
    logic [DEF_SEL_BITS-1:0] rdst;
    logic                    wr_en;
  } slot_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vec_pipe_slot.sv
// One pipeline slot: valid bit plus flat payload with load, hold and kill.
// Kill clears only the valid bit; the payload is don't-care once invalid.
module vec_pipe_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         kill,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (kill) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= in_valid;
      data  <= in_data;
    end
  end

endmodule

// File: rtl/vec_pipe_chain.sv
// Stall/flush-able instruction pipeline with read-after-write hazard detection.
// Define VEC_PIPE_STATS_EN to add saturating stall/bubble/flush counters.
module vec_pipe_chain
  import vec_pipe_pkg::*;
#(
  parameter int unsigned REGISTER_SIZE = DEF_REGISTER_SIZE,
  parameter int unsigned VECTOR_SIZE   = DEF_VECTOR_SIZE,
  parameter int unsigned SEL_BITS      = DEF_SEL_BITS,
  parameter int unsigned CTRL_W        = DEF_CTRL_W,
  parameter int unsigned STAGES        = DEF_STAGES
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  input  logic [CTRL_W-1:0]                         in_ctrl,
  input  logic [VECTOR_SIZE-1:0][REGISTER_SIZE-1:0] in_vec1,
  input  logic [VECTOR_SIZE-1:0][REGISTER_SIZE-1:0] in_vec2,
  input  logic [SEL_BITS-1:0]                       in_rsel1,
  input  logic [SEL_BITS-1:0]                       in_rsel2,
  input  logic [SEL_BITS-1:0]                       in_rdst,
  input  logic                                      in_wr_en,
  input  logic                                      stall,
  input  logic                                      flush,
  output logic                                      in_ready,
  output logic                                      hazard,
  output logic                                      out_valid,
  output logic [CTRL_W-1:0]                         out_ctrl,
  output logic [VECTOR_SIZE-1:0][REGISTER_SIZE-1:0] out_vec1,
  output logic [VECTOR_SIZE-1:0][REGISTER_SIZE-1:0] out_vec2,
  output logic [SEL_BITS-1:0]                       out_rdst,
  output logic                                      out_wr_en,
  output logic [$clog2(STAGES+1)-1:0]               occupancy
`ifdef VEC_PIPE_STATS_EN
  ,
  output logic [15:0]                               stall_cnt,
  output logic [15:0]                               bubble_cnt,
  output logic [15:0]                               flush_cnt
`endif
);

  localparam int unsigned OCC_W = $clog2(STAGES+1);
  localparam int unsigned PW    = CTRL_W + 2*VECTOR_SIZE*REGISTER_SIZE + SEL_BITS + 1;

  logic [STAGES-1:0] valid;
  logic [PW-1:0]     slot_data [STAGES];
  logic [PW-1:0]     pay_in;
  logic              accept;
  logic              shift_en;

  // Payload layout: {ctrl, vec1, vec2, rdst, wr_en}; wr_en at bit 0, rdst just above.
  assign pay_in   = {in_ctrl, in_vec1, in_vec2, in_rdst, in_wr_en};
  assign in_ready = !stall && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  assign shift_en = !stall;

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (in_valid && valid[i] && slot_data[i][0] &&
          (slot_data[i][SEL_BITS:1] == in_rsel1 || slot_data[i][SEL_BITS:1] == in_rsel2))
        hazard = 1'b1;
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_slot
    if (g == 0) begin : g_head
      vec_pipe_slot #(.W(PW)) u_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (shift_en),
        .kill     (flush),
        .in_valid (accept),
        .in_data  (pay_in),
        .valid    (valid[g]),
        .data     (slot_data[g])
      );
    end else begin : g_body
      vec_pipe_slot #(.W(PW)) u_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (shift_en),
        .kill     (flush),
        .in_valid (valid[g-1]),
        .in_data  (slot_data[g-1]),
        .valid    (valid[g]),
        .data     (slot_data[g])
      );
    end
  end

  assign out_valid = valid[STAGES-1];
  assign {out_ctrl, out_vec1, out_vec2, out_rdst, out_wr_en} = slot_data[STAGES-1];

  always_comb begin
    occupancy = '0;
    for (int unsigned i = 0; i < STAGES; i++)
      occupancy = occupancy + OCC_W'(valid[i]);
  end

`ifdef VEC_PIPE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (stall)
        stall_cnt <= sat_inc16(stall_cnt);
      if (flush)
        flush_cnt <= sat_inc16(flush_cnt);
      if (!stall && !flush && !accept)
        bubble_cnt <= sat_inc16(bubble_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_vec_pipe_chain.sv
// Self-checking bench for vec_pipe_chain: queue-based age model plus directed vectors.
// Counter checks are included when VEC_PIPE_STATS_EN is defined.
module tb_vec_pipe_chain;
  import vec_pipe_pkg::*;

  localparam int unsigned STAGES = 3;
  localparam int unsigned CTRL_W = 25;
  localparam int unsigned SEL_B  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  vec_t              in_vec1 = '0;
  vec_t              in_vec2 = '0;
  logic [SEL_B-1:0]  in_rsel1 = '0;
  logic [SEL_B-1:0]  in_rsel2 = '0;
  logic [SEL_B-1:0]  in_rdst = '0;
  logic              in_wr_en = 1'b0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic              in_ready, hazard, out_valid, out_wr_en;
  logic [CTRL_W-1:0] out_ctrl;
  vec_t              out_vec1, out_vec2;
  logic [SEL_B-1:0]  out_rdst;
  logic [1:0]        occupancy;
`ifdef VEC_PIPE_STATS_EN
  logic [15:0]       stall_cnt, bubble_cnt, flush_cnt;
`endif

  int tests  = 0;
  int failed = 0;

  vec_pipe_chain #(
    .REGISTER_SIZE (8),
    .VECTOR_SIZE   (4),
    .SEL_BITS      (SEL_B),
    .CTRL_W        (CTRL_W),
    .STAGES        (STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ctrl   (in_ctrl),
    .in_vec1   (in_vec1),
    .in_vec2   (in_vec2),
    .in_rsel1  (in_rsel1),
    .in_rsel2  (in_rsel2),
    .in_rdst   (in_rdst),
    .in_wr_en  (in_wr_en),
    .stall     (stall),
    .flush     (flush),
    .in_ready  (in_ready),
    .hazard    (hazard),
    .out_valid (out_valid),
    .out_ctrl  (out_ctrl),
    .out_vec1  (out_vec1),
    .out_vec2  (out_vec2),
    .out_rdst  (out_rdst),
    .out_wr_en (out_wr_en),
    .occupancy (occupancy)
`ifdef VEC_PIPE_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted instruction carries its age in shift edges; it is visible
  // at the output when age == STAGES and gone once age exceeds STAGES.
  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    vec_t              v1;
    vec_t              v2;
    logic [SEL_B-1:0]  rdst;
    logic              wr;
    int unsigned       age;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_stall = '0, m_bubble = '0, m_flush = '0;

  function automatic logic m_hazard();
    logic h = 1'b0;
    foreach (q[i])
      if (in_valid && q[i].wr && (q[i].rdst == in_rsel1 || q[i].rdst == in_rsel2)) h = 1'b1;
    return h;
  endfunction

  function automatic logic m_ready();
    return !stall && !flush && !m_hazard();
  endfunction

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always @(posedge clk or negedge rst) begin
    logic acc;
    ent_t e;
    if (!rst) begin
      q.delete();
      m_stall = '0; m_bubble = '0; m_flush = '0;
    end else begin
      acc = in_valid && m_ready();
      if (stall) m_stall = sat(m_stall);
      if (flush) m_flush = sat(m_flush);
      if (!stall && !flush && !acc) m_bubble = sat(m_bubble);
      if (flush) q.delete();
      else if (!stall) begin
        foreach (q[i]) q[i].age++;
        while (q.size() > 0 && q[0].age > STAGES) void'(q.pop_front());
        if (acc) begin
          e.ctrl = in_ctrl; e.v1 = in_vec1; e.v2 = in_vec2;
          e.rdst = in_rdst; e.wr = in_wr_en; e.age = 1;
          q.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic ov;
    ov = (q.size() > 0) && (q[0].age == STAGES);
    chk("out_valid", 64'(out_valid), 64'(ov));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("hazard", 64'(hazard), 64'(m_hazard()));
    chk("in_ready", 64'(in_ready), 64'(m_ready()));
    if (ov) begin
      chk("out_ctrl", 64'(out_ctrl), 64'(q[0].ctrl));
      chk("out_vec1", 64'(out_vec1), 64'(q[0].v1));
      chk("out_vec2", 64'(out_vec2), 64'(q[0].v2));
      chk("out_rdst", 64'(out_rdst), 64'(q[0].rdst));
      chk("out_wr_en", 64'(out_wr_en), 64'(q[0].wr));
    end
`ifdef VEC_PIPE_STATS_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
    chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
  end

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [SEL_B-1:0] rd,
                       input logic wr, input logic [SEL_B-1:0] r1, input logic [SEL_B-1:0] r2,
                       input logic st, input logic fl);
    in_valid = v; in_ctrl = c; in_rdst = rd; in_wr_en = wr;
    in_rsel1 = r1; in_rsel2 = r2; stall = st; flush = fl;
    in_vec1  = {c[7:0], ~c[7:0], c[15:8], 8'h3C};
    in_vec2  = $urandom;
  endtask

  task automatic idle();
    drive(1'b0, '0, 4'd0, 1'b0, 4'd15, 4'd15, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic v; logic [CTRL_W-1:0] c; logic [SEL_B-1:0] rd; logic wr;
    logic [SEL_B-1:0] r1; logic [SEL_B-1:0] r2; logic st; logic fl;
  } vec_row_t;

  vec_row_t tbl[16];

  int unsigned occ_seq[4] = '{1, 1, 1, 0};
  logic        ov_seq[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
`ifdef VEC_PIPE_STATS_EN
  logic [15:0] b0;
  logic [15:0] f0;
`endif

  initial begin
    tbl[0]  = '{1'b1, 25'h1A, 4'd2, 1'b1, 4'd7, 4'd8, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 25'h1B, 4'd3, 1'b1, 4'd9, 4'd2, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 25'h1C, 4'd5, 1'b0, 4'd3, 4'd1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 25'h1D, 4'd6, 1'b1, 4'd11, 4'd12, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 25'h1E, 4'd6, 1'b1, 4'd11, 4'd12, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 25'h1F, 4'd1, 1'b0, 4'd6, 4'd6, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 25'h20, 4'd1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 25'h21, 4'd9, 1'b1, 4'd13, 4'd14, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 25'h22, 4'd10, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 25'h23, 4'd9, 1'b0, 4'd9, 4'd9, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 25'h1FFFFFF, 4'd15, 1'b1, 4'd1, 4'd2, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 25'h24, 4'd4, 1'b0, 4'd14, 4'd15, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 25'h25, 4'd4, 1'b0, 4'd14, 4'd15, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 25'h26, 4'd4, 1'b0, 4'd15, 4'd3, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 25'h27, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 25'h28, 4'd8, 1'b1, 4'd8, 4'd8, 1'b0, 1'b0};

    // Reset state
    idle();
    step(); step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_out_vec1", 64'(out_vec1), 64'd0);
    rst = 1'b1;
    step();

    // Single instruction latency and occupancy profile
    drive(1'b1, 25'h0000A5, 4'd0, 1'b0, 4'd15, 4'd15, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) idle();
      chk("lat_occupancy", 64'(occupancy), 64'(occ_seq[k]));
      chk("lat_out_valid", 64'(out_valid), 64'(ov_seq[k]));
      if (k == 2) chk("lat_out_ctrl", 64'(out_ctrl), 64'h0000A5);
    end

    // RAW hazard holds the reader off for exactly STAGES cycles
    drive(1'b1, 25'h0000C1, 4'd4, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
    step();
`ifdef VEC_PIPE_STATS_EN
    b0 = bubble_cnt;
`endif
    drive(1'b1, 25'h0000C2, 4'd5, 1'b0, 4'd4, 4'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("raw_hazard", 64'(hazard), 64'd1);
      chk("raw_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    #1;
    chk("raw_release_hazard", 64'(hazard), 64'd0);
    chk("raw_release_ready", 64'(in_ready), 64'd1);
    step();
    idle();
`ifdef VEC_PIPE_STATS_EN
    chk("raw_bubbles", 64'(bubble_cnt - b0), 64'd3);
`endif
    repeat (4) step();

    // Fill three then stall five cycles
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 25'h101 + 25'(k), 4'd0, 1'b0, 4'd15, 4'd15, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 25'h1AA, 4'd0, 1'b0, 4'd15, 4'd15, 1'b1, 1'b0);
`ifdef VEC_PIPE_STATS_EN
    b0 = stall_cnt;
`endif
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_out_ctrl", 64'(out_ctrl), 64'h101);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_occupancy", 64'(occupancy), 64'd3);
    end
`ifdef VEC_PIPE_STATS_EN
    chk("stall_cnt_5", 64'(stall_cnt - b0), 64'd5);
    f0 = flush_cnt;
`endif

    // Flush beats stall
    drive(1'b1, 25'h1BB, 4'd0, 1'b0, 4'd15, 4'd15, 1'b1, 1'b1);
    step();
    chk("flush_occupancy", 64'(occupancy), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
`ifdef VEC_PIPE_STATS_EN
    chk("flush_cnt_1", 64'(flush_cnt - f0), 64'd1);
`endif
    idle();
    step();

    // Asynchronous reset with two valid slots, checked before the next edge
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 25'h201 + 25'(k), 4'd0, 1'b0, 4'd15, 4'd15, 1'b0, 1'b0);
      step();
    end
    idle();
    step();
    chk("pre_rst_occupancy", 64'(occupancy), 64'd2);
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_occupancy", 64'(occupancy), 64'd0);
    step();
    rst = 1'b1;
    step();

    // Mixed directed stream
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].c, tbl[i].rd, tbl[i].wr, tbl[i].r1, tbl[i].r2, tbl[i].st, tbl[i].fl);
      step();
    end
    idle();
    repeat (5) step();

`ifdef VEC_PIPE_STATS_EN
    // Saturation of the stall counter
    drive(1'b0, '0, 4'd0, 1'b0, 4'd15, 4'd15, 1'b1, 1'b0);
    repeat (70000) step();
    chk("stall_cnt_sat", 64'(stall_cnt), 64'hFFFF);
    idle();
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
